// File: rtl/cgra_pkg.sv
// Shared types for the CGRA instruction-memory write path.
package cgra_pkg;
    localparam int INST_W = 20;
    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;
endpackage

// File: rtl/instmem_loader.sv
// Packs a 20-bit instruction stream MSB-first into 64-bit words
// and writes them into the PE instruction memory.
module instmem_loader
    import cgra_pkg::*;
#(
    parameter int WRITE_AWIDTH = 6,
    parameter int WRITE_DWIDTH = WORD_W,
    parameter int READ_AWIDTH  = 7,
    parameter int READ_DWIDTH  = INST_W,
    parameter int MAX_INST     = 128
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    inst_valid,
    input  logic [READ_DWIDTH-1:0]  inst_data,
    output logic                    inst_ready,
    input  logic                    flush,
    output logic                    Write_En,
    output logic [WRITE_AWIDTH-1:0] Write_Addr,
    output logic [WRITE_DWIDTH-1:0] In_Inst,
    output logic                    done,
    output logic [READ_AWIDTH:0]    inst_count
);

    localparam int FW = $clog2(WRITE_DWIDTH);
    localparam int SW = 2 * WRITE_DWIDTH;
    localparam logic [FW:0] FULL_AT = (FW+1)'(WRITE_DWIDTH);
    localparam logic [FW:0] INST_BITS = (FW+1)'(READ_DWIDTH);
    localparam logic [READ_AWIDTH:0] LAST_CNT = (READ_AWIDTH+1)'(MAX_INST - 1);

    state_t state, state_nx;

    logic [WRITE_DWIDTH-1:0] acc;
    logic [FW-1:0]           fill;
    logic [WRITE_AWIDTH-1:0] addr;

    logic                    accept;
    logic [SW-1:0]           wide;
    logic [FW:0]             fsum;
    logic                    full;
    logic                    last;

    logic                    we_nx;
    logic                    done_nx;
    logic [WRITE_DWIDTH-1:0] word_nx;

    assign accept = inst_valid & inst_ready;

    // acc is zero below the pending bits, so OR-ing the shifted
    // instruction in is a splice; the top half is the emitted word
    // and the bottom half the residual.
    always_comb begin
        wide = {acc, {WRITE_DWIDTH{1'b0}}}
             | ({inst_data, {(SW-READ_DWIDTH){1'b0}}} >> fill);
        fsum = {1'b0, fill} + INST_BITS;
        full = fsum >= FULL_AT;
        last = inst_count == LAST_CNT;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD: begin
                if (accept && last) state_nx = S_DONE;
                else if (flush)     state_nx = S_FLUSH;
            end
            S_FLUSH: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        we_nx   = 1'b0;
        done_nx = 1'b0;
        word_nx = wide[SW-1 -: WRITE_DWIDTH];
        unique case (state)
            S_LOAD:  we_nx = accept & full;
            S_FLUSH: begin
                we_nx   = fill != '0;
                word_nx = acc;
            end
            S_DONE:  done_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            inst_ready <= 1'b0;
            Write_En   <= 1'b0;
            Write_Addr <= '0;
            In_Inst    <= '0;
            done       <= 1'b0;
            inst_count <= '0;
            acc        <= '0;
            fill       <= '0;
            addr       <= '0;
        end else begin
            inst_ready <= state_nx == S_LOAD;
            Write_En   <= we_nx;
            done       <= done_nx;
            if (we_nx) begin
                Write_Addr <= addr;
                In_Inst    <= word_nx;
                addr       <= addr + 1'b1;
            end
            if (state == S_IDLE && start) begin
                acc        <= '0;
                fill       <= '0;
                addr       <= '0;
                inst_count <= '0;
            end else if (accept) begin
                acc        <= full ? wide[WRITE_DWIDTH-1:0]
                                   : wide[SW-1 -: WRITE_DWIDTH];
                fill       <= fsum[FW-1:0];
                inst_count <= inst_count + 1'b1;
            end
        end
    end

endmodule
